// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the data-memory controller.
package data_mem_ctrl_pkg;

  // Access size as presented by the core; encoding 2'b11 is handled as a word.
  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } memSize_t;

  // Controller state.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } dmcState_t;

  // Load data returned when the memory never acknowledges.
  localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

  // Keep-mask for right-justified load data of the given size.
  function automatic logic [31:0] size_mask(input logic [1:0] size);
    logic [31:0] m;
    case (size)
      MEM_BYTE: m = 32'h0000_00FF;
      MEM_HALF: m = 32'h0000_FFFF;
      default:  m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_lane_align.sv
// Byte-lane steering: store replication and byte enables, load shift/mask,
// and misalignment detection. Purely combinational.
module mem_lane_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [1:0]  req_off_i,    // byte offset of the incoming request
  input  logic [1:0]  req_size_i,   // size of the incoming request
  input  logic [31:0] st_data_i,    // right-justified store data
  output logic [31:0] st_wdata_o,   // lane-replicated store data
  output logic [3:0]  st_be_o,      // store byte enables
  output logic        misaligned_o, // request violates natural alignment
  input  logic [1:0]  ld_off_i,     // byte offset of the captured access
  input  logic [1:0]  ld_size_i,    // size of the captured access
  input  logic [31:0] ld_raw_i,     // raw memory word
  output logic [31:0] ld_data_o     // right-justified, zero-extended load data
);

  logic [31:0] ld_shifted;

  // Store-side steering and alignment check for the request being issued.
  always_comb begin
    st_wdata_o   = st_data_i;
    st_be_o      = 4'b1111;
    misaligned_o = 1'b0;
    case (req_size_i)
      MEM_BYTE: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        st_be_o    = 4'b0001 << req_off_i;
      end
      MEM_HALF: begin
        st_wdata_o   = {2{st_data_i[15:0]}};
        st_be_o      = 4'b0011 << req_off_i;
        misaligned_o = req_off_i[0];
      end
      default: begin
        misaligned_o = |req_off_i;
      end
    endcase
  end

  // Load-side right-justification of the returned word.
  always_comb begin
    ld_shifted = ld_raw_i >> {ld_off_i, 3'b000};
    ld_data_o  = ld_shifted & size_mask(ld_size_i);
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Core data-port to word-wide memory bridge with byte enables, variable ack
// latency, misalignment detection and an ack timeout.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       i_data_addr,
  input  logic [31:0]       i_data_wr,
  input  logic [1:0]        i_data_size,
  input  logic              i_data_rd_en,
  input  logic              i_data_wr_en,
  output logic              o_data_ready,
  output logic [31:0]       o_data_rd,
  output logic              o_misaligned,
  output logic              o_bus_err,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_be,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata
);

  localparam int unsigned   TW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  dmcState_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [31:0]       rd_q, rd_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              mis_q, mis_d;
  logic              berr_q, berr_d;

  logic              req_any;
  logic              timed_out;
  logic [31:0]       lane_wdata;
  logic [3:0]        lane_be;
  logic              lane_mis;
  logic [31:0]       lane_ld;

  // Address bits above the memory window simply wrap.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^i_data_addr[31:ADDR_W+2];

  assign req_any   = i_data_rd_en | i_data_wr_en;
  assign timed_out = (timer_q == TMAX);

  mem_lane_align u_lane (
    .req_off_i    (i_data_addr[1:0]),
    .req_size_i   (i_data_size),
    .st_data_i    (i_data_wr),
    .st_wdata_o   (lane_wdata),
    .st_be_o      (lane_be),
    .misaligned_o (lane_mis),
    .ld_off_i     (off_q),
    .ld_size_i    (size_q),
    .ld_raw_i     (i_mem_rdata),
    .ld_data_o    (lane_ld)
  );

  // State register; async reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_any) state_d = lane_mis ? RESP : REQ;
      REQ:  if (i_mem_ack || timed_out) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs derived from the current state.
  always_comb begin
    o_mem_req    = 1'b0;
    o_data_ready = 1'b0;
    case (state_q)
      IDLE: o_data_ready = ~req_any;
      REQ:  o_mem_req    = 1'b1;
      RESP: o_data_ready = 1'b1;
      default: o_data_ready = 1'b0;
    endcase
  end

  // Datapath next values: request capture, ack timer, response data and flags.
  // Flags are set only on the transition into RESP, which lasts one cycle, so
  // they read as single-cycle pulses aligned with RESP.
  always_comb begin
    addr_d  = addr_q;
    off_d   = off_q;
    size_d  = size_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rd_d    = rd_q;
    timer_d = timer_q;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (req_any) begin
          if (lane_mis) begin
            rd_d  = '0;
            mis_d = 1'b1;
          end else begin
            addr_d  = i_data_addr[ADDR_W+1:2];
            off_d   = i_data_addr[1:0];
            size_d  = i_data_size;
            we_d    = i_data_wr_en;
            be_d    = i_data_wr_en ? lane_be : 4'b1111;
            wdata_d = lane_wdata;
          end
        end
      end
      REQ: begin
        if (i_mem_ack) begin
          rd_d = lane_ld;
        end else if (timed_out) begin
          rd_d   = BUS_ERR_DATA;
          berr_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      timer_q <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      timer_q <= timer_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign o_mem_we     = we_q;
  assign o_mem_be     = be_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_data_rd    = rd_q;
  assign o_misaligned = mis_q;
  assign o_bus_err    = berr_q;

endmodule
